exec_writeback: RTL and testbench
=================================

Name: exec_writeback

Overview:
Execute and writeback stage of the pipelined CPU. It accepts decoded instructions from the ID/EX pipeline register and computes the ALU result, using an iterative multiplier for MUL. It drives the register-file write port (we, r_write_enc, wdata), which closes the loop on the read-only front end. While a multi-cycle op is in flight it back-pressures fetch and decode through stall_out.

Parameters:
DATA_W, 32, operand/result width
ENC_W, 2, register encoding width
CNT_W, 16, retire counter width

Ports:
clk  in  1  clock, all state on rising edge
resetn  in  1  asynchronous active-low reset
hold  in  1  freeze request (e.g. ~KEY[2])
id_valid  in  1  ID/EX holds a valid instruction
id_mode  in  1  0 = register operand B, 1 = immediate operand B
id_opcode  in  3  operation
id_val1  in  DATA_W  register-file read 0 (operand A)
id_val2  in  DATA_W  register-file read 1 (operand B when mode=0)
id_imm  in  ENC_W  instr[1:0], zero-extended as B when mode=1
id_wb_enc  in  ENC_W  destination register
stall_out  out  1  upstream must hold IF/ID and ID/EX
rf_we  out  1  register-file write enable
rf_wenc  out  ENC_W  write destination
rf_wdata  out  DATA_W  write data
last_result  out  DATA_W  last written value (display)
retire_cnt  out  CNT_W  count of retired instructions

Behaviour:
- Interface decision: one clock, clk; reset is asynchronous and active-low, resetn.
- Reset: state=IDLE; rf_we=0, rf_wenc=0, rf_wdata=0, last_result=0, retire_cnt=0, multiplier registers=0. If reset arrives mid-MUL, the MUL is abandoned and no write occurs.
- Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL by B[4:0], 110 MUL (low DATA_W bits), 111 NOP.
- All arithmetic is modulo 2^DATA_W. SUB wraps (0-1 = 0xFFFFFFFF). Shift amounts of 0..31 are legal.
- Accept: an instruction is accepted on a rising edge when id_valid=1, hold=0 and state=IDLE.
- Single-cycle ops: accepting edge E loads the WB register, and rf_we=1 for exactly the cycle after E. The register file commits at the end of that cycle. Latency is 1 cycle, with back-to-back throughput of 1 per cycle.
- NOP retires (retire_cnt+1) but never asserts rf_we.
- FSM states: IDLE, MUL.
  - IDLE->MUL on accepting a MUL; load acc=0, mcand=A, mplier=B.
  - In MUL, each non-hold cycle:
    - if mplier==0: WB register<=acc, next state IDLE;
    - else: acc+=mcand when mplier[0]=1; then mcand<<=1, mplier>>=1.
  - MUL cycle count is (index of highest set bit of B)+2; B=0 gives 1 cycle, then rf_we.
- stall_out = (state==MUL) | hold, combinational.
- hold=1 freezes everything: no accept, no MUL step, rf_we forced 0. A pending write is retained and issued in the first cycle after hold drops.
- retire_cnt increments once per retirement and wraps from 0xFFFF to 0. last_result updates only when rf_we=1.
- id_* inputs are ignored while state=MUL.

Optional Feature:
EXWB_FORWARD_EN:
- Defined: adds inputs id_rs0_enc and id_rs1_enc (ENC_W each). When rf_we=1 in the accepting cycle and an rsN_enc equals rf_wenc, the corresponding operand is replaced with rf_wdata. This covers the write/read same-cycle hazard. Immediate B is never replaced.
- Undefined: the ports are absent and operands are used as given. Software must insert one NOP between dependent instructions.

Decomposition:
- Package cpu_pkg holds:
  - opcode localparams OP_ADD..OP_NOP;
  - state encoding ST_IDLE/ST_MUL;
  - DATA_W and ENC_W defaults.
- One sub-module, iter_multiplier (start, A, B, busy, done, product), owns the shift-add datapath. The FSM stays in exec_writeback.

Test Plan:
- Reset, then ADD mode=0 with val1=5, val2=7, wb_enc=1 -> next cycle rf_we=1, rf_wenc=1, rf_wdata=12, retire_cnt=1.
- SUB with 0-1, then ADD mode=1 with val1=3, imm=2 on back-to-back cycles -> rf_wdata=0xFFFFFFFF, then 5 on consecutive cycles.
- MUL with A=6, B=5 -> stall_out high 4 cycles, then rf_wdata=30. MUL with B=0 -> stall_out 1 cycle, then rf_wdata=0.
- hold asserted the cycle after ADD accept -> rf_we stays 0 while held; value written the first cycle after release; retire_cnt increments once.
- resetn low mid-MUL -> rf_we never asserts, stall_out=0, retire_cnt=0 immediately (asynchronous).
- (EXWB_FORWARD_EN) ADD R0=1+1, then ADD R1=R0+R0 back-to-back with stale val=0 -> second write is 4; without the macro it is 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, FSM state encoding and width defaults for exec_writeback
package cpu_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ENC_W  = 2;
    localparam int DEF_CNT_W  = 16;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_NOP = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/exec_writeback_if.sv
// rtl/exec_writeback_if.sv - ID/EX instruction bus with stall back-pressure (EXWB_FORWARD_EN adds source encodings)
interface exec_writeback_if #(
    parameter int DATA_W = 32,
    parameter int ENC_W  = 2
);
    logic              id_valid;
    logic              id_mode;
    logic [2:0]        id_opcode;
    logic [DATA_W-1:0] id_val1;
    logic [DATA_W-1:0] id_val2;
    logic [ENC_W-1:0]  id_imm;
    logic [ENC_W-1:0]  id_wb_enc;
`ifdef EXWB_FORWARD_EN
    logic [ENC_W-1:0]  id_rs0_enc;
    logic [ENC_W-1:0]  id_rs1_enc;
`endif
    logic              stall_out;

`ifdef EXWB_FORWARD_EN
    modport master (
        output id_valid, id_mode, id_opcode, id_val1, id_val2, id_imm, id_wb_enc,
               id_rs0_enc, id_rs1_enc,
        input  stall_out
    );
    modport slave (
        input  id_valid, id_mode, id_opcode, id_val1, id_val2, id_imm, id_wb_enc,
               id_rs0_enc, id_rs1_enc,
        output stall_out
    );
`else
    modport master (
        output id_valid, id_mode, id_opcode, id_val1, id_val2, id_imm, id_wb_enc,
        input  stall_out
    );
    modport slave (
        input  id_valid, id_mode, id_opcode, id_val1, id_val2, id_imm, id_wb_enc,
        output stall_out
    );
`endif
endinterface

// File: rtl/iter_multiplier.sv
// rtl/iter_multiplier.sv - shift-add multiplier, one partial product per step, exits when multiplier is exhausted
module iter_multiplier #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              step,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] product
);
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] mcand;
    logic [DATA_W-1:0] mplier;

    // Load operands on start; each step consumes one multiplier bit, the zero-multiplier step ends the run
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
            busy   <= 1'b1;
        end else if (step && busy) begin
            if (mplier == '0) begin
                busy <= 1'b0;
            end else begin
                if (mplier[0]) acc <= acc + mcand;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
            end
        end
    end

    // Product is final once no multiplier bits remain
    always_comb begin
        done    = busy && (mplier == '0);
        product = acc;
    end
endmodule

// File: rtl/exec_writeback.sv
// rtl/exec_writeback.sv - execute/writeback stage: ALU, iterative MUL, register-file write port (EXWB_FORWARD_EN: operand forwarding)
module exec_writeback
    import cpu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ENC_W  = DEF_ENC_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              hold,
    exec_writeback_if.slave   id,
    output logic              rf_we,
    output logic [ENC_W-1:0]  rf_wenc,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [DATA_W-1:0] last_result,
    output logic [CNT_W-1:0]  retire_cnt
);
    state_t            state, state_nx;
    logic              accept, mul_start, mul_step, mul_retire;
    logic              mul_busy, mul_done;
    logic [DATA_W-1:0] mul_product;
    logic [DATA_W-1:0] op_a, op_b, alu_res;
    logic [ENC_W-1:0]  mul_enc;
    logic              wb_pending;

    // Operand select; forwarding covers the write that commits in the same cycle as the read
    always_comb begin
        op_a = id.id_val1;
        op_b = id.id_mode ? DATA_W'(id.id_imm) : id.id_val2;
`ifdef EXWB_FORWARD_EN
        if (rf_we && (id.id_rs0_enc == rf_wenc)) op_a = rf_wdata;
        if (!id.id_mode && rf_we && (id.id_rs1_enc == rf_wenc)) op_b = rf_wdata;
`endif
    end

    // Single-cycle ALU; MUL and NOP results come from elsewhere or are discarded
    always_comb begin
        alu_res = '0;
        case (id.id_opcode)
            OP_ADD:  alu_res = op_a + op_b;
            OP_SUB:  alu_res = op_a - op_b;
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_SHL:  alu_res = op_a << op_b[4:0];
            default: alu_res = '0;
        endcase
    end

    iter_multiplier #(.DATA_W(DATA_W)) u_mul (
        .clk     (clk),
        .resetn  (resetn),
        .start   (mul_start),
        .step    (mul_step),
        .a       (op_a),
        .b       (op_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // FSM state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nx;
    end

    // FSM next state: enter MUL on an accepted MUL, leave when the multiplier reports done
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (accept && (id.id_opcode == OP_MUL)) state_nx = ST_MUL;
            ST_MUL:  if (mul_retire) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // FSM outputs: accept/step qualifiers, back-pressure and gated write enable
    always_comb begin
        accept       = id.id_valid && !hold && (state == ST_IDLE);
        mul_start    = accept && (id.id_opcode == OP_MUL);
        mul_step     = (state == ST_MUL) && !hold && mul_busy;
        mul_retire   = mul_step && mul_done;
        id.stall_out = (state == ST_MUL) || hold;
        rf_we        = wb_pending && !hold;
    end

    // Writeback register: loaded on retirement, pending write survives hold, last_result tracks commits
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wb_pending  <= 1'b0;
            rf_wenc     <= '0;
            rf_wdata    <= '0;
            last_result <= '0;
            retire_cnt  <= '0;
            mul_enc     <= '0;
        end else begin
            if (rf_we) begin
                last_result <= rf_wdata;
                wb_pending  <= 1'b0;
            end
            if (accept && (id.id_opcode != OP_MUL)) begin
                retire_cnt <= retire_cnt + CNT_W'(1);
                if (id.id_opcode != OP_NOP) begin
                    wb_pending <= 1'b1;
                    rf_wenc    <= id.id_wb_enc;
                    rf_wdata   <= alu_res;
                end
            end else if (mul_retire) begin
                retire_cnt <= retire_cnt + CNT_W'(1);
                wb_pending <= 1'b1;
                rf_wenc    <= mul_enc;
                rf_wdata   <= mul_product;
            end
            if (mul_start) mul_enc <= id.id_wb_enc;
        end
    end
endmodule

// File: tb/tb_exec_writeback.sv
// tb/tb_exec_writeback.sv - directed-vector bench for exec_writeback
module tb_exec_writeback;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        hold = 1'b0;
    logic        rf_we;
    logic [1:0]  rf_wenc;
    logic [31:0] rf_wdata;
    logic [31:0] last_result;
    logic [15:0] retire_cnt;

    int n_vec = 0;
    int n_bad = 0;

    exec_writeback_if #(.DATA_W(32), .ENC_W(2)) bus ();

    exec_writeback #(.DATA_W(32), .ENC_W(2), .CNT_W(16)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .hold        (hold),
        .id          (bus),
        .rf_we       (rf_we),
        .rf_wenc     (rf_wenc),
        .rf_wdata    (rf_wdata),
        .last_result (last_result),
        .retire_cnt  (retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic mode, input logic [31:0] v1,
                         input logic [31:0] v2, input logic [1:0] imm, input logic [1:0] wb);
        bus.id_valid  = 1'b1;
        bus.id_opcode = op;
        bus.id_mode   = mode;
        bus.id_val1   = v1;
        bus.id_val2   = v2;
        bus.id_imm    = imm;
        bus.id_wb_enc = wb;
    endtask

    task automatic idle();
        bus.id_valid  = 1'b0;
        bus.id_opcode = OP_NOP;
    endtask

    task automatic count_stall(output int cnt);
        cnt = 0;
        while (bus.stall_out === 1'b1 && cnt < 40) begin
            cnt++;
            cyc();
        end
    endtask

    initial begin
        int cnt;
        logic saw_we;
        idle();
        issue(OP_NOP, 1'b0, 32'd0, 32'd0, 2'd0, 2'd0);
        idle();
`ifdef EXWB_FORWARD_EN
        bus.id_rs0_enc = 2'd3;
        bus.id_rs1_enc = 2'd3;
`endif
        #12;
        chk("reset_we",     {31'd0, rf_we}, 32'd0);
        chk("reset_wdata",  rf_wdata, 32'd0);
        chk("reset_retire", {16'd0, retire_cnt}, 32'd0);
        chk("reset_stall",  {31'd0, bus.stall_out}, 32'd0);
        chk("reset_last",   last_result, 32'd0);
        resetn = 1'b1;
        cyc();

        issue(OP_ADD, 1'b0, 32'd5, 32'd7, 2'd0, 2'd1);
        cyc();
        idle();
        chk("add_we",     {31'd0, rf_we}, 32'd1);
        chk("add_wenc",   {30'd0, rf_wenc}, 32'd1);
        chk("add_wdata",  rf_wdata, 32'd12);
        chk("add_retire", {16'd0, retire_cnt}, 32'd1);

        issue(OP_SUB, 1'b0, 32'd0, 32'd1, 2'd0, 2'd2);
        cyc();
        chk("sub_we",    {31'd0, rf_we}, 32'd1);
        chk("sub_wdata", rf_wdata, 32'hFFFF_FFFF);
        chk("sub_last",  last_result, 32'd12);
        issue(OP_ADD, 1'b1, 32'd3, 32'd100, 2'd2, 2'd3);
        cyc();
        idle();
        chk("addi_wdata",  rf_wdata, 32'd5);
        chk("addi_wenc",   {30'd0, rf_wenc}, 32'd3);
        chk("addi_retire", {16'd0, retire_cnt}, 32'd3);

        issue(OP_SHL, 1'b0, 32'd1, 32'd31, 2'd0, 2'd0);
        cyc();
        chk("shl31_wdata", rf_wdata, 32'h8000_0000);
        issue(OP_SHL, 1'b0, 32'd3, 32'd0, 2'd0, 2'd0);
        cyc();
        chk("shl0_wdata", rf_wdata, 32'd3);
        issue(OP_AND, 1'b0, 32'h0000_F0F0, 32'h0000_FF00, 2'd0, 2'd0);
        cyc();
        chk("and_wdata", rf_wdata, 32'h0000_F000);
        issue(OP_OR, 1'b0, 32'h0000_F0F0, 32'h0000_FF00, 2'd0, 2'd0);
        cyc();
        chk("or_wdata", rf_wdata, 32'h0000_FFF0);
        issue(OP_XOR, 1'b0, 32'h0000_F0F0, 32'h0000_FF00, 2'd0, 2'd0);
        cyc();
        idle();
        chk("xor_wdata", rf_wdata, 32'h0000_0FF0);
        cyc();
        chk("idle_we",   {31'd0, rf_we}, 32'd0);
        chk("idle_last", last_result, 32'h0000_0FF0);

        issue(OP_MUL, 1'b0, 32'd6, 32'd5, 2'd0, 2'd2);
        cyc();
        idle();
        chk("mul_busy_we", {31'd0, rf_we}, 32'd0);
        count_stall(cnt);
        chk("mul_stall_cycles", cnt, 32'd4);
        chk("mul_we",     {31'd0, rf_we}, 32'd1);
        chk("mul_wenc",   {30'd0, rf_wenc}, 32'd2);
        chk("mul_wdata",  rf_wdata, 32'd30);
        chk("mul_retire", {16'd0, retire_cnt}, 32'd9);

        issue(OP_MUL, 1'b0, 32'd9, 32'd0, 2'd0, 2'd1);
        cyc();
        idle();
        count_stall(cnt);
        chk("mul0_stall_cycles", cnt, 32'd1);
        chk("mul0_we",    {31'd0, rf_we}, 32'd1);
        chk("mul0_wdata", rf_wdata, 32'd0);
        cyc();

        issue(OP_ADD, 1'b0, 32'd10, 32'd20, 2'd0, 2'd3);
        cyc();
        idle();
        hold = 1'b1;
        #1;
        chk("hold_we",     {31'd0, rf_we}, 32'd0);
        chk("hold_stall",  {31'd0, bus.stall_out}, 32'd1);
        chk("hold_retire", {16'd0, retire_cnt}, 32'd11);
        cyc();
        chk("hold2_we", {31'd0, rf_we}, 32'd0);
        hold = 1'b0;
        #1;
        chk("release_we",    {31'd0, rf_we}, 32'd1);
        chk("release_wdata", rf_wdata, 32'd30);
        cyc();
        chk("after_we",     {31'd0, rf_we}, 32'd0);
        chk("after_retire", {16'd0, retire_cnt}, 32'd11);
        chk("after_last",   last_result, 32'd30);

        issue(OP_NOP, 1'b0, 32'd1, 32'd1, 2'd0, 2'd0);
        cyc();
        idle();
        chk("nop_we",     {31'd0, rf_we}, 32'd0);
        chk("nop_retire", {16'd0, retire_cnt}, 32'd12);

        issue(OP_ADD, 1'b0, 32'd1, 32'd1, 2'd0, 2'd0);
        cyc();
        chk("fwd_first", rf_wdata, 32'd2);
        issue(OP_ADD, 1'b0, 32'd0, 32'd0, 2'd0, 2'd1);
`ifdef EXWB_FORWARD_EN
        bus.id_rs0_enc = 2'd0;
        bus.id_rs1_enc = 2'd0;
`endif
        cyc();
        idle();
`ifdef EXWB_FORWARD_EN
        chk("fwd_second", rf_wdata, 32'd4);
        bus.id_rs0_enc = 2'd3;
        bus.id_rs1_enc = 2'd3;
`else
        chk("fwd_second", rf_wdata, 32'd0);
`endif
        cyc();

        issue(OP_MUL, 1'b0, 32'd3, 32'h0000_00FF, 2'd0, 2'd2);
        cyc();
        idle();
        cyc();
        resetn = 1'b0;
        #1;
        chk("rst_mid_stall",  {31'd0, bus.stall_out}, 32'd0);
        chk("rst_mid_we",     {31'd0, rf_we}, 32'd0);
        chk("rst_mid_retire", {16'd0, retire_cnt}, 32'd0);
        cyc();
        resetn = 1'b1;
        saw_we = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (rf_we !== 1'b0 || bus.stall_out !== 1'b0) saw_we = 1'b1;
        end
        chk("rst_mid_no_write", {31'd0, saw_we}, 32'd0);

        issue(OP_NOP, 1'b0, 32'd0, 32'd0, 2'd0, 2'd0);
        repeat (65535) cyc();
        chk("retire_max",  {16'd0, retire_cnt}, 32'h0000_FFFF);
        cyc();
        idle();
        chk("retire_wrap", {16'd0, retire_cnt}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
